dmem_responder: RTL

Data-memory responder for the pipelined RISC-V core: the memory-side end of the MEM-stage store/load interface that the core drives with MemWrite/DataAdr/WriteData. It accepts one request at a time with a valid/ready handshake, inserts a configurable number of wait states, and performs byte/halfword/word stores with lane insertion and loads with sign/zero extension. It replaces the zero-latency behavioural data memory, so the hazard unit's stall path can be exercised.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/dmem_lane_align.sv | 57 +++++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared funct3 codes, data-memory FSM states and request check.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Unsigned sizes exist only for loads; everything else unlisted is illegal.
    function automatic logic dmemReqErr(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addrLo);
        logic legal;
        logic aligned;
        legal   = 1'b1;
        aligned = 1'b1;
        case (funct3)
            F3_B:    ;
            F3_H:    aligned = ~addrLo[0];
            F3_W:    aligned = (addrLo == 2'b00);
            F3_BU:   legal   = ~we;
            F3_HU: begin
                legal   = ~we;
                aligned = ~addrLo[0];
            end
            default: legal = 1'b0;
        endcase
        return ~(legal & aligned);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Byte-lane steering: store enables/replication, load extraction.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]  i_addrLo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byteEn,
    output logic [31:0] o_wdataRep,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rword >> {i_addrLo, 3'b000};

    always_comb begin
        o_byteEn   = 4'b0000;
        o_wdataRep = i_wdata;
        o_rdata    = 32'h0000_0000;
        case (i_funct3)
            F3_B: begin
                o_byteEn   = 4'b0001 << i_addrLo;
                o_wdataRep = {4{i_wdata[7:0]}};
                o_rdata    = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            F3_BU: begin
                o_byteEn   = 4'b0001 << i_addrLo;
                o_wdataRep = {4{i_wdata[7:0]}};
                o_rdata    = {24'h00_0000, w_shifted[7:0]};
            end
            F3_H: begin
                o_byteEn   = 4'b0011 << {i_addrLo[1], 1'b0};
                o_wdataRep = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            F3_HU: begin
                o_byteEn   = 4'b0011 << {i_addrLo[1], 1'b0};
                o_wdataRep = {2{i_wdata[15:0]}};
                o_rdata    = {16'h0000, w_shifted[15:0]};
            end
            F3_W: begin
                o_byteEn = 4'b1111;
                o_rdata  = i_rword;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Valid/ready data-memory responder with programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         c_ADR_W     = c_IDX_W + 2;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dmem_state_t        r_state;
    logic [3:0]         r_waitCnt;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [c_ADR_W-1:0] r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_fromInputs;
    logic               w_opWe;
    logic [2:0]         w_opF3;
    logic [c_ADR_W-1:0] w_opAddr;
    logic [31:0]        w_opWdata;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_err;
    logic               w_enterResp;
    logic               w_memWrite;
    logic [3:0]         w_byteEn;
    logic [31:0]        w_wdataRep;
    logic [31:0]        w_loadData;
    logic [31:0]        w_rspData;
    logic               w_unusedAddr;

    // With zero wait states the operation completes straight from the request inputs.
    assign w_fromInputs = (r_state == IDLE);
    assign w_opWe       = w_fromInputs ? req_we                  : r_we;
    assign w_opF3       = w_fromInputs ? req_funct3              : r_funct3;
    assign w_opAddr     = w_fromInputs ? req_addr[c_ADR_W-1:0]   : r_addr;
    assign w_opWdata    = w_fromInputs ? req_wdata               : r_wdata;
    assign w_idx        = w_opAddr[c_ADR_W-1:2];
    assign w_err        = dmemReqErr(w_opWe, w_opF3, w_opAddr[1:0]);

    assign w_enterResp  = ((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                          ((r_state == WAIT) && (r_waitCnt == 4'd0));
    assign w_memWrite   = w_enterResp && !reset && w_opWe && !w_err;
    assign w_rspData    = (w_opWe || w_err) ? 32'h0000_0000 : w_loadData;
    assign w_unusedAddr = &{1'b0, req_addr[31:c_ADR_W]};

    dmem_lane_align u_laneAlign (
        .i_addrLo   (w_opAddr[1:0]),
        .i_funct3   (w_opF3),
        .i_wdata    (w_opWdata),
        .i_rword    (r_mem[w_idx]),
        .o_byteEn   (w_byteEn),
        .o_wdataRep (w_wdataRep),
        .o_rdata    (w_loadData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_waitCnt <= 4'd0;
            r_we      <= 1'b0;
            r_funct3  <= 3'b000;
            r_addr    <= '0;
            r_wdata   <= 32'h0000_0000;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
            if (w_enterResp) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= w_rspData;
                rsp_err   <= w_err;
            end
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_addr    <= req_addr[c_ADR_W-1:0];
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= RESP;
                        end else begin
                            r_state   <= WAIT;
                            r_waitCnt <= c_WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state <= RESP;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    r_state   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage is deliberately not reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (w_memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdataRep[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
